// File: rtl/dac_pattern_player.sv
// dac_pattern_player
// Replays a waveform held in an on-chip sample memory as a 128-bit
// AXI4-Stream (eight 16-bit samples per beat, sample 0 in bits [15:0])
// towards the DAC stream input, either once (one-shot) or continuously.
//
// Ports:
//   aclk, aresetn      sole clock; asynchronous active-low reset
//   wr_en/addr/data    sample memory write port, usable in any state
//   play_last          index of the final beat of the pattern (latched at start)
//   loop_en            1 = wrap continuously, 0 = one-shot (latched at start)
//   start, stop        single-cycle start / abort requests
//   busy               high from accepted start until back in IDLE
//   done               one-cycle pulse after the last one-shot beat is accepted
//   m_axis_*           AXI4-Stream master towards the DAC
module dac_pattern_player #(
    parameter int DAC_WIDTH  = 128,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DAC_WIDTH-1:0]  wr_data,
    input  logic [DEPTH_LOG2-1:0] play_last,
    input  logic                  loop_en,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic [DAC_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]            state;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] last_q;
    logic                  loop_q;
    logic                  issue_done;

    logic [DAC_WIDTH-1:0]  mem [2**DEPTH_LOG2];
    logic [DAC_WIDTH-1:0]  rd_data;
    logic                  rd_valid;
    logic                  rd_last;

    // Two-entry output FIFO; the head entry is the stream output register.
    logic [DAC_WIDTH-1:0]  head_data;
    logic                  head_valid;
    logic                  head_last;
    logic [DAC_WIDTH-1:0]  tail_data;
    logic                  tail_valid;
    logic                  tail_last;

    logic       rst_n;
    logic [1:0] rst_sync;
    logic       pop;
    logic       push;
    logic       flush;
    logic       issue;
    logic [2:0] level;

    // Reset asserts immediately but is released only after two clean clock edges.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign pop   = head_valid & m_axis_tready;
    assign push  = rd_valid & (state == S_PLAY);
    assign flush = ((state == S_PLAY) & stop) | (state == S_FLUSH);

    // Level counts buffered plus in-flight beats after this cycle's pop, so a
    // read can be issued every cycle while the stream is accepting.
    assign level = {2'b00, head_valid} + {2'b00, tail_valid} + {2'b00, rd_valid}
                 - {2'b00, pop};
    assign issue = (state == S_PLAY) & ~stop & ~issue_done & (level < 3'd2);

    // Sample memory: read-first on a collision because both use the old array value.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (issue) rd_data <= mem[rd_ptr];
    end

    // Playback FSM, read pointer and done pulse.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            last_q     <= '0;
            loop_q     <= 1'b0;
            issue_done <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= issue & ~flush;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_PLAY;
                        last_q     <= play_last;
                        loop_q     <= loop_en;
                        rd_ptr     <= '0;
                        issue_done <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        state <= S_FLUSH;
                    end else if (!loop_q && pop && head_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (issue) begin
                rd_last <= (rd_ptr == last_q);
                if (rd_ptr == last_q) begin
                    rd_ptr <= '0;
                    if (!loop_q) issue_done <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Output FIFO: the head is refilled from the tail first, then from the
    // memory; an empty head is zeroed so tdata reads 0 whenever tvalid is low.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            head_data  <= '0;
            head_valid <= 1'b0;
            head_last  <= 1'b0;
            tail_data  <= '0;
            tail_valid <= 1'b0;
            tail_last  <= 1'b0;
        end else if (flush) begin
            head_data  <= '0;
            head_valid <= 1'b0;
            head_last  <= 1'b0;
            tail_valid <= 1'b0;
            tail_last  <= 1'b0;
        end else if (!head_valid || pop) begin
            if (tail_valid) begin
                head_data  <= tail_data;
                head_valid <= 1'b1;
                head_last  <= tail_last;
                tail_valid <= push;
                if (push) begin
                    tail_data <= rd_data;
                    tail_last <= rd_last;
                end
            end else if (push) begin
                head_data  <= rd_data;
                head_valid <= 1'b1;
                head_last  <= rd_last;
            end else begin
                head_data  <= '0;
                head_valid <= 1'b0;
                head_last  <= 1'b0;
            end
        end else if (push) begin
            tail_data  <= rd_data;
            tail_valid <= 1'b1;
            tail_last  <= rd_last;
        end
    end

    assign busy          = (state != S_IDLE);
    assign m_axis_tdata  = head_data;
    assign m_axis_tvalid = head_valid;

endmodule
